// File: rtl/input_conditioner.sv
// Synchronises and debounces the DE0 pushbuttons and slide switches into the clock domain.
// Optional auto-repeat of button_press while a button is held: define INPUT_COND_REPEAT_EN.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clock,
    input  logic       reset_signal,
    input  logic [2:0] button_n,
    input  logic [7:0] sw_raw,
    output logic [2:0] button_level,
    output logic [2:0] button_press,
    output logic [2:0] button_release,
    output logic [7:0] sw_stable,
    output logic       sw_changed
);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if ((64'd1 << CNT_WIDTH) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_width
        $error("CNT_WIDTH too small for DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 2");
    end

    logic [2:0] btn_meta_r;
    logic [2:0] btn_sync2_r;
    logic [7:0] sw_meta_r;
    logic [7:0] sw_sync_r;
    logic [2:0] btn_sync_s;

    // Two-flop synchronisers; buttons idle high (released), switches idle low
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            btn_meta_r  <= 3'b111;
            btn_sync2_r <= 3'b111;
            sw_meta_r   <= 8'h00;
            sw_sync_r   <= 8'h00;
        end else begin
            btn_meta_r  <= button_n;
            btn_sync2_r <= btn_meta_r;
            sw_meta_r   <= sw_raw;
            sw_sync_r   <= sw_meta_r;
        end
    end

    assign btn_sync_s = ~btn_sync2_r;

    btn_state_t           state_r [3];
    btn_state_t           state_s [3];
    logic [CNT_WIDTH-1:0] cnt_r   [3];
    logic [CNT_WIDTH-1:0] cnt_s   [3];
    logic [CNT_WIDTH-1:0] inc_s   [3];
    logic [2:0]           level_r;
    logic [2:0]           level_s;
    logic [2:0]           press_r;
    logic [2:0]           press_s;
    logic [2:0]           release_r;
    logic [2:0]           release_s;

`ifdef INPUT_COND_REPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_r [3];
    logic [RPT_W-1:0] rpt_s [3];
`endif

    // Per-button debounce FSM next-state and pulse generation
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_s[i]   = state_r[i];
            cnt_s[i]     = cnt_r[i];
            inc_s[i]     = (cnt_r[i] == CNT_LAST) ? CNT_LAST : cnt_r[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            level_s[i]   = level_r[i];
            press_s[i]   = 1'b0;
            release_s[i] = 1'b0;
`ifdef INPUT_COND_REPEAT_EN
            rpt_s[i]     = rpt_r[i];
`endif
            case (state_r[i])
                ST_RELEASED: begin
                    cnt_s[i] = '0;
                    if (btn_sync_s[i]) begin
                        state_s[i] = ST_PRESS_WAIT;
                    end else begin
                        state_s[i] = ST_RELEASED;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!btn_sync_s[i]) begin
                        state_s[i] = ST_RELEASED;
                        cnt_s[i]   = '0;
                    end else if (inc_s[i] == CNT_LAST) begin
                        state_s[i] = ST_HELD;
                        cnt_s[i]   = '0;
                        level_s[i] = 1'b1;
                        press_s[i] = 1'b1;
`ifdef INPUT_COND_REPEAT_EN
                        rpt_s[i]   = '0;
`endif
                    end else begin
                        cnt_s[i] = inc_s[i];
                    end
                end
                ST_HELD: begin
                    if (!btn_sync_s[i]) begin
                        state_s[i] = ST_RELEASE_WAIT;
                        cnt_s[i]   = '0;
                    end else begin
                        state_s[i] = ST_HELD;
`ifdef INPUT_COND_REPEAT_EN
                        if (rpt_r[i] == RPT_LAST) begin
                            rpt_s[i]   = '0;
                            press_s[i] = 1'b1;
                        end else begin
                            rpt_s[i] = rpt_r[i] + {{(RPT_W-1){1'b0}}, 1'b1};
                        end
`endif
                    end
                end
                ST_RELEASE_WAIT: begin
                    // The repeat counter is left untouched here so it resumes on return
                    if (btn_sync_s[i]) begin
                        state_s[i] = ST_HELD;
                        cnt_s[i]   = '0;
                    end else if (inc_s[i] == CNT_LAST) begin
                        state_s[i]   = ST_RELEASED;
                        cnt_s[i]     = '0;
                        level_s[i]   = 1'b0;
                        release_s[i] = 1'b1;
                    end else begin
                        cnt_s[i] = inc_s[i];
                    end
                end
                default: begin
                    state_s[i] = ST_RELEASED;
                    cnt_s[i]   = '0;
                    level_s[i] = 1'b0;
                end
            endcase
        end
    end

    // Button FSM state, counters and registered outputs
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= ST_RELEASED;
                cnt_r[i]   <= '0;
`ifdef INPUT_COND_REPEAT_EN
                rpt_r[i]   <= '0;
`endif
            end
            level_r   <= 3'b000;
            press_r   <= 3'b000;
            release_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
`ifdef INPUT_COND_REPEAT_EN
                rpt_r[i]   <= rpt_s[i];
`endif
            end
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= release_s;
        end
    end

    logic [7:0]           sw_prev_r;
    logic [7:0]           sw_stable_r;
    logic [7:0]           sw_stable_s;
    logic [CNT_WIDTH-1:0] sw_cnt_r;
    logic [CNT_WIDTH-1:0] sw_cnt_s;
    logic [CNT_WIDTH-1:0] sw_inc_s;
    logic                 sw_changed_r;
    logic                 sw_changed_s;

    // Shared switch debouncer: any new pattern mid-count restarts the count
    always_comb begin
        sw_stable_s  = sw_stable_r;
        sw_cnt_s     = sw_cnt_r;
        sw_changed_s = 1'b0;
        sw_inc_s     = (sw_cnt_r == CNT_LAST) ? CNT_LAST : sw_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (sw_sync_r == sw_stable_r) begin
            sw_cnt_s = '0;
        end else if (sw_sync_r != sw_prev_r) begin
            sw_cnt_s = '0;
        end else if (sw_inc_s == CNT_LAST) begin
            sw_stable_s  = sw_sync_r;
            sw_changed_s = 1'b1;
            sw_cnt_s     = '0;
        end else begin
            sw_cnt_s = sw_inc_s;
        end
    end

    // Switch debouncer state and registered outputs
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            sw_prev_r    <= 8'h00;
            sw_stable_r  <= 8'h00;
            sw_cnt_r     <= '0;
            sw_changed_r <= 1'b0;
        end else begin
            sw_prev_r    <= sw_sync_r;
            sw_stable_r  <= sw_stable_s;
            sw_cnt_r     <= sw_cnt_s;
            sw_changed_r <= sw_changed_s;
        end
    end

    assign button_level   = level_r;
    assign button_press   = press_r;
    assign button_release = release_r;
    assign sw_stable      = sw_stable_r;
    assign sw_changed     = sw_changed_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=8, CNT_WIDTH=4, REPEAT_CYCLES=20.
module tb_input_conditioner;

    logic       clock = 1'b0;
    logic       reset_signal = 1'b1;
    logic [2:0] button_n = 3'b111;
    logic [7:0] sw_raw = 8'h00;
    logic [2:0] button_level;
    logic [2:0] button_press;
    logic [2:0] button_release;
    logic [7:0] sw_stable;
    logic       sw_changed;

    int vectors = 0;
    int miscompares = 0;

    int cyc;
    int press_cnt [3];
    int press_at  [3];
    int press_last[3];
    int rel_cnt   [3];
    int rel_at    [3];
    int chg_cnt;
    int chg_at;
    bit seen_5a;

    input_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .CNT_WIDTH(4),
        .REPEAT_CYCLES(20)
    ) dut (
        .clock(clock),
        .reset_signal(reset_signal),
        .button_n(button_n),
        .sw_raw(sw_raw),
        .button_level(button_level),
        .button_press(button_press),
        .button_release(button_release),
        .sw_stable(sw_stable),
        .sw_changed(sw_changed)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_watch();
        cyc = 0;
        chg_cnt = 0;
        chg_at = 0;
        for (int b = 0; b < 3; b++) begin
            press_cnt[b] = 0; press_at[b] = 0; press_last[b] = 0;
            rel_cnt[b] = 0; rel_at[b] = 0;
        end
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            cyc++;
            for (int b = 0; b < 3; b++) begin
                if (button_press[b]) begin
                    press_cnt[b]++;
                    if (press_cnt[b] == 1) press_at[b] = cyc;
                    press_last[b] = cyc;
                end
                if (button_release[b]) begin
                    rel_cnt[b]++;
                    if (rel_cnt[b] == 1) rel_at[b] = cyc;
                end
            end
            if (sw_changed) begin
                chg_cnt++;
                if (chg_cnt == 1) chg_at = cyc;
            end
            if (sw_stable == 8'h5A) seen_5a = 1'b1;
        end
    endtask

    initial begin
        clear_watch();
        seen_5a = 1'b0;
        // Reset state
        run(3);
        check("rst_level", 32'(button_level), 32'h0);
        check("rst_press", 32'(button_press), 32'h0);
        check("rst_release", 32'(button_release), 32'h0);
        check("rst_sw_stable", 32'(sw_stable), 32'h0);
        check("rst_sw_changed", 32'(sw_changed), 32'h0);
        reset_signal = 1'b0;
        clear_watch();
        run(12);
        check("idle_no_events", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + chg_cnt), 32'h0);

        // Clean press on button 2
        clear_watch();
        button_n = 3'b011;
        run(9);
        check("press2_level_c9", 32'(button_level), 32'h0);
        run(11);
        check("press2_at", 32'(press_at[2]), 32'd10);
        check("press2_count", 32'(press_cnt[2]), 32'd1);
        check("press2_level", 32'(button_level), 32'h4);
        check("press2_others", 32'(press_cnt[0] + press_cnt[1] + rel_cnt[2] + chg_cnt), 32'h0);

        // Release of button 2
        clear_watch();
        button_n = 3'b111;
        run(12);
        check("rel2_at", 32'(rel_at[2]), 32'd10);
        check("rel2_count", 32'(rel_cnt[2]), 32'd1);
        check("rel2_level", 32'(button_level), 32'h0);

        // Bounce rejection on button 0
        clear_watch();
        button_n = 3'b110; run(5);
        button_n = 3'b111; run(1);
        button_n = 3'b110; run(5);
        button_n = 3'b111; run(12);
        check("bounce0_press", 32'(press_cnt[0]), 32'd0);
        check("bounce0_level", 32'(button_level), 32'h0);
        clear_watch();
        button_n = 3'b110;
        run(12);
        check("press0_at", 32'(press_at[0]), 32'd10);
        check("press0_level", 32'(button_level), 32'h1);

        // Button 1 press, 3-cycle glitch while held, then release
        clear_watch();
        button_n = 3'b100;
        run(12);
        check("press1_at", 32'(press_at[1]), 32'd10);
        clear_watch();
        button_n = 3'b110; run(3);
        button_n = 3'b100; run(15);
        check("glitch1_pulses", 32'(press_cnt[1] + rel_cnt[1]), 32'd0);
        check("glitch1_level", 32'(button_level), 32'h3);
        clear_watch();
        button_n = 3'b110;
        run(12);
        check("rel1_at", 32'(rel_at[1]), 32'd10);
        check("rel1_level", 32'(button_level[1]), 32'h0);
        button_n = 3'b111;
        run(12);
        check("rel0_level", 32'(button_level), 32'h0);

        // Switch retarget mid-count
        seen_5a = 1'b0;
        clear_watch();
        sw_raw = 8'h5A; run(4);
        clear_watch();
        sw_raw = 8'hA5; run(9);
        check("sw_c9_stable", 32'(sw_stable), 32'h0);
        check("sw_c9_changed", 32'(chg_cnt), 32'd0);
        run(6);
        check("sw_chg_at", 32'(chg_at), 32'd10);
        check("sw_chg_count", 32'(chg_cnt), 32'd1);
        check("sw_stable_a5", 32'(sw_stable), 32'hA5);
        check("sw_never_5a", 32'(seen_5a), 32'd0);

        // Asynchronous reset while button 2 is in PRESS_WAIT with count 5
        clear_watch();
        button_n = 3'b011;
        run(8);
        #2;
        reset_signal = 1'b1;
        #1;
        check("async_rst_sw", 32'(sw_stable), 32'h0);
        check("async_rst_level", 32'(button_level), 32'h0);
        @(posedge clock);
        #1;
        reset_signal = 1'b0;
        clear_watch();
        run(12);
        check("post_rst_press_at", 32'(press_at[2]), 32'd10);
        check("post_rst_level", 32'(button_level), 32'h4);
        check("post_rst_sw_at", 32'(chg_at), 32'd10);
        check("post_rst_sw", 32'(sw_stable), 32'hA5);
        button_n = 3'b111;
        run(12);

        // Long hold: auto-repeat only when the feature is built
        clear_watch();
        button_n = 3'b110;
        run(70);
        button_n = 3'b111;
        run(12);
        check("hold_first_at", 32'(press_at[0]), 32'd10);
`ifdef INPUT_COND_REPEAT_EN
        check("hold_press_count", 32'(press_cnt[0]), 32'd4);
        check("hold_last_at", 32'(press_last[0]), 32'd70);
`else
        check("hold_press_count", 32'(press_cnt[0]), 32'd1);
        check("hold_last_at", 32'(press_last[0]), 32'd10);
`endif
        check("hold_rel_at", 32'(rel_at[0]), 32'd80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
